// File: rtl/rr_stream_arb_pkg.sv
// Shared types and helpers for the round-robin packet stream arbiter.
// therm_mask is sized for the widest supported arbiter; callers keep the low bits.
package rr_stream_arb_pkg;

   localparam int unsigned MaxReq = 32;

   typedef enum logic {
      ARB,
      LOCK
   } arb_state_e;

   // Bit i is set for every index strictly above the previous winner.
   function automatic logic [MaxReq-1:0] therm_mask(input int unsigned last_idx);
      logic [MaxReq-1:0] mask;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         mask[i] = (i > last_idx);
      end
      return mask;
   endfunction

endpackage

// File: rtl/rr_stream_arb_fpa.sv
// Fixed-priority thermometer arbiter: lowest masked request wins, else lowest request.
// Also muxes the winning requester's payload.
module fpa #(
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [REQ_NUM-1:0]            req,
   input  logic [REQ_NUM-1:0]            prio,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] data_in,
   output logic [REQ_NUM-1:0]            gnt,
   output logic [DATA_WIDTH-1:0]         data_out
);

   logic [REQ_NUM-1:0] masked;
   logic               found;

   assign masked = req & prio;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (!found && masked[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      // Nothing above the pointer: wrap to the lowest requester.
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      data_out = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (gnt[i]) begin
            data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/rr_stream_arb.sv
// Round-robin, packet-aware valid/ready stream arbiter with a registered output slice.
// A grant is locked from a packet's first beat to its last so packets never interleave.
module rr_stream_arb
   import rr_stream_arb_pkg::*;
#(
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   localparam int unsigned IDX_W     = $clog2(REQ_NUM)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [REQ_NUM-1:0]            in_valid,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] in_data,
   input  logic [REQ_NUM-1:0]            in_last,
   output logic [REQ_NUM-1:0]            in_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [IDX_W-1:0]              out_src,
   input  logic                          out_ready
);

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      last_idx_q, last_idx_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic [IDX_W-1:0]      out_src_q, out_src_d;

   logic [MaxReq-1:0]     mask_full;
   logic [REQ_NUM-1:0]    prio;
   logic [REQ_NUM-1:0]    fpa_gnt;
   logic [DATA_WIDTH-1:0] fpa_data;
   logic [IDX_W-1:0]      gnt_idx;
   logic [IDX_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;
   logic                  load;
   logic                  hs;
   logic                  unused_mask;

   assign load        = !out_valid_q || out_ready;
   assign mask_full   = therm_mask(32'(last_idx_q));
   assign prio        = mask_full[REQ_NUM-1:0];
   assign unused_mask = ^mask_full[MaxReq-1:REQ_NUM];

   fpa #(
      .REQ_NUM    (REQ_NUM),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fpa (
      .req      (in_valid),
      .prio     (prio),
      .data_in  (in_data),
      .gnt      (fpa_gnt),
      .data_out (fpa_data)
   );

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (fpa_gnt[i]) begin
            gnt_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_idx_d  = last_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      in_ready    = '0;
      hs          = 1'b0;
      sel_idx     = gnt_idx;
      sel_data    = fpa_data;

      unique case (state_q)
         ARB: begin
            in_ready = fpa_gnt & {REQ_NUM{load}};
            hs       = (|(in_valid & fpa_gnt)) && load;
         end
         LOCK: begin
            // Only the owner may advance; a dropped valid is a bubble, not a release.
            in_ready[owner_q] = load;
            hs                = in_valid[owner_q] && load;
            sel_idx           = owner_q;
            sel_data          = in_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
         end
         default: ;
      endcase

      sel_last = in_last[sel_idx];

      if (hs) begin
         if (sel_last) begin
            state_d    = ARB;
            last_idx_d = sel_idx;
         end else begin
            state_d = LOCK;
            owner_d = sel_idx;
         end
      end

      if (load) begin
         out_valid_d = hs;
         if (hs) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_src_d  = sel_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         owner_q     <= '0;
         last_idx_q  <= IDX_W'(REQ_NUM - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_idx_q  <= last_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_stream_arb.sv
// Self-checking bench for rr_stream_arb: a rotating-search reference model fills a
// scoreboard of expected output beats; directed grant-order checks follow each scenario.
module tb_rr_stream_arb;

   localparam int unsigned REQ_NUM    = 4;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned IDX_W      = 2;

   typedef struct packed {
      logic [IDX_W-1:0]      src;
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   logic                          clk;
   logic                          rst_n;
   logic [REQ_NUM-1:0]            in_valid;
   logic [REQ_NUM*DATA_WIDTH-1:0] in_data;
   logic [REQ_NUM-1:0]            in_last;
   logic [REQ_NUM-1:0]            in_ready;
   logic                          out_valid;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          out_last;
   logic [IDX_W-1:0]              out_src;
   logic                          out_ready;

   rr_stream_arb #(
      .REQ_NUM    (REQ_NUM),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   beat_t       sb[$];
   int          grant_log[$];
   logic        m_lock;
   int          m_owner;
   int          m_last;
   logic [5:0]  cnt;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_lock  = 1'b0;
      m_owner = 0;
      m_last  = REQ_NUM - 1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic ordy);
      in_valid  = v;
      in_last   = l;
      out_ready = ordy;
      for (int i = 0; i < REQ_NUM; i++) begin
         in_data[i*DATA_WIDTH +: DATA_WIDTH] = {2'(i), cnt};
      end
      cnt++;
   endtask

   // seq holds one grant index per hex nibble, oldest first.
   task automatic check_log(input string tag, input int n, input logic [31:0] seq);
      check_val({tag, "_count"}, grant_log.size(), n);
      for (int k = 0; k < n && k < grant_log.size(); k++) begin
         check_val($sformatf("%s_grant%0d", tag, k), grant_log[k],
                   (seq >> (4 * (n - 1 - k))) & 32'hF);
      end
      grant_log.delete();
   endtask

   task automatic step();
      logic [3:0] exp_rdy;
      logic       load;
      int         win;
      int         idx;
      beat_t      b;
      @(negedge clk);
      check_val("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
         b = sb[0];
         check_val("out_src", out_src, b.src);
         check_val("out_data", out_data, b.data);
         check_val("out_last", out_last, b.last);
      end
      load    = (sb.size() == 0) || out_ready;
      exp_rdy = '0;
      win     = -1;
      if (load) begin
         if (m_lock) begin
            win = m_owner;
         end else begin
            for (int k = 1; k <= REQ_NUM; k++) begin
               idx = (m_last + k) % REQ_NUM;
               if (win < 0 && in_valid[idx]) win = idx;
            end
         end
         if (win >= 0) exp_rdy[win] = 1'b1;
      end
      check_val("in_ready", in_ready, exp_rdy);
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (win >= 0 && in_valid[win]) begin
         b.src  = IDX_W'(win);
         b.data = in_data[win*DATA_WIDTH +: DATA_WIDTH];
         b.last = in_last[win];
         sb.push_back(b);
         grant_log.push_back(win);
         if (in_last[win]) begin
            m_lock = 1'b0;
            m_last = win;
         end else begin
            m_lock  = 1'b1;
            m_owner = win;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      cnt = '0;
      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", out_valid, 0);
      check_val("rst_data", out_data, 0);
      check_val("rst_src", out_src, 0);
      check_val("rst_last", out_last, 0);
      rst_n = 1'b1;

      // Round-robin over all single-beat requesters, starting at index 0.
      for (int s = 0; s < 5; s++) begin
         drive(4'b1111, 4'b1111, 1'b1);
         step();
      end
      drive(4'b0000, 4'b0000, 1'b1); step();
      check_log("rr_all", 5, 32'h01230);

      // Wrap-around and masked priority.
      drive(4'b0010, 4'b1111, 1'b1); step();
      drive(4'b0001, 4'b1111, 1'b1); step();
      drive(4'b1001, 4'b1111, 1'b1); step();
      drive(4'b0000, 4'b0000, 1'b1); step();
      check_log("wrap", 3, 32'h103);

      // Three-beat packet from requester 2 amid competing requesters.
      drive(4'b0010, 4'b1111, 1'b1); step();
      drive(4'b1111, 4'b1011, 1'b1); step();
      drive(4'b1111, 4'b1011, 1'b1); step();
      drive(4'b1111, 4'b1111, 1'b1); step();
      drive(4'b1111, 4'b1111, 1'b1); step();
      drive(4'b0000, 4'b0000, 1'b1); step();
      check_log("packet", 5, 32'h12223);

      // Owner 1 bubbles for two cycles while requester 0 waits.
      drive(4'b0010, 4'b0000, 1'b1); step();
      drive(4'b0001, 4'b1111, 1'b1); step();
      drive(4'b0001, 4'b1111, 1'b1); step();
      drive(4'b0011, 4'b0010, 1'b1); step();
      drive(4'b0001, 4'b1111, 1'b1); step();
      drive(4'b0000, 4'b0000, 1'b1); step();
      check_log("bubble", 3, 32'h110);

      // Backpressure holds the A5 beat and blocks all requesters.
      drive(4'b0100, 4'b0100, 1'b1);
      in_data[2*DATA_WIDTH +: DATA_WIDTH] = 8'hA5;
      step();
      for (int s = 0; s < 3; s++) begin
         drive(4'b1111, 4'b1111, 1'b0);
         step();
         check_val("stall_data", out_data, 8'hA5);
         check_val("stall_src", out_src, 2);
         check_val("stall_rdy", in_ready, 4'b0000);
      end
      drive(4'b1111, 4'b1111, 1'b1); step();
      drive(4'b0000, 4'b0000, 1'b1); step();
      check_log("stall", 2, 32'h23);

      // Reset in the middle of a packet owned by requester 2.
      drive(4'b0100, 4'b0000, 1'b1); step();
      drive(4'b0100, 4'b0000, 1'b1); step();
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", out_valid, 0);
      check_val("mid_rst_data", out_data, 0);
      check_val("mid_rst_src", out_src, 0);
      check_val("mid_rst_last", out_last, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(4'b0100, 4'b0100, 1'b1); step();
      drive(4'b0000, 4'b0000, 1'b1); step();
      step();
      check_log("reset", 3, 32'h222);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
